// File: rtl/lsu_pkg.sv
// lsu_pkg: shared access-size/state types and lane-mask helpers for the load/store path
package lsu_pkg;
    typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10, BAD = 2'b11} mem_size_t;
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} lsu_state_t;
    localparam logic [3:0] BASE_BYTE = 4'b0001;
    localparam logic [3:0] BASE_HALF = 4'b0011;
    localparam logic [3:0] BASE_WORD = 4'b1111;
    function automatic logic [3:0] baseMask(input mem_size_t s);
        return s == BYTE ? BASE_BYTE : s == HALF ? BASE_HALF : s == WORD ? BASE_WORD : 4'b0000;
    endfunction
endpackage

// File: rtl/lsu_extend.sv
// lsu_extend: zero/sign extension of right-justified load data by access size
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [31:0] data,
    input  mem_size_t   size,
    input  logic        signExt,
    output logic [31:0] result
);
    assign result = size == BYTE ? {{24{signExt & data[7]}}, data[7:0]} :
                    size == HALF ? {{16{signExt & data[15]}}, data[15:0]} : data;
endmodule

// File: rtl/lsu_align.sv
// lsu_align: byte/half/word load-store initiator that splits word-crossing accesses in two
module lsu_align
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    lsu_state_t        state, stateNext;
    mem_size_t         sizeQ;
    logic              weQ, signedQ;
    logic [ADDR_W-1:0] addrQ;
    logic [31:0]       wdataQ, loQ, rShift, extData;
    logic [ADDR_W-3:0] wordAddr;
    logic [1:0]        off;
    logic [7:0]        m8;
    logic [63:0]       w64, rCat;
    logic              split, acc, hiAcc, done;
    assign off      = addrQ[1:0];
    assign wordAddr = addrQ[ADDR_W-1:2];
    assign split    = (sizeQ == HALF && off == 2'd3) || (sizeQ == WORD && off != 2'd0);
    assign m8       = {4'b0000, baseMask(sizeQ)} << off;
    assign w64      = {32'b0, wdataQ} << {off, 3'b000};
    // lo word was captured during ACC1; the hi word arrives on mem_rdata in DONE
    assign rCat     = split ? {mem_rdata, loQ} : {32'b0, mem_rdata};
    assign rShift   = 32'(rCat >> {off, 3'b000});
    assign acc      = state == ACC0 || state == ACC1;
    assign hiAcc    = state == ACC1;
    assign done     = state == DONE;
    assign req_ready  = state == IDLE;
    assign mem_en     = acc;
    assign mem_we     = acc && weQ;
    assign mem_be     = !acc ? 4'b0000 : hiAcc ? m8[7:4] : m8[3:0];
    assign mem_addr   = !acc ? '0 : hiAcc ? wordAddr + 1'b1 : wordAddr;
    assign mem_wdata  = !acc ? 32'b0 : hiAcc ? w64[63:32] : w64[31:0];
    assign resp_valid = done;
    assign resp_err   = done && sizeQ == BAD;
    assign resp_rdata = (done && !weQ && sizeQ != BAD) ? extData : 32'b0;
    lsu_extend uExtend (
        .data   (rShift),
        .size   (sizeQ),
        .signExt(signedQ),
        .result (extData)
    );
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: if (req_valid) stateNext = mem_size_t'(req_size) == BAD ? DONE : ACC0;
            ACC0: stateNext = split ? ACC1 : DONE;
            ACC1: stateNext = DONE;
            DONE: stateNext = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            weQ     <= 1'b0;
            sizeQ   <= BYTE;
            signedQ <= 1'b0;
            addrQ   <= '0;
            wdataQ  <= 32'b0;
            loQ     <= 32'b0;
        end else begin
            state <= stateNext;
            if (req_valid && req_ready) begin
                weQ     <= req_we;
                sizeQ   <= mem_size_t'(req_size);
                signedQ <= req_signed;
                addrQ   <= req_addr;
                wdataQ  <= req_wdata;
            end
            if (hiAcc) loQ <= mem_rdata;
        end
    end
endmodule
